// File: rtl/score_keeper_pkg.sv
// Shared constants, state encoding and the per-tick penalty rule for score_keeper.
// Grace constants exist only when LATE_GRACE_EN is defined.
package score_keeper_pkg;

  localparam int                NOTE_W    = 5;
  localparam int                SCORE_W   = 14;
  localparam int                PEN_W     = 4;
  localparam logic [NOTE_W-1:0] REST      = 5'd0;
  localparam logic [PEN_W-1:0]  PEN_MISS  = 4'd2;
  localparam logic [PEN_W-1:0]  PEN_EXTRA = 4'd1;
  localparam logic [SCORE_W-1:0] SCORE_MAX = 14'h3FFF;

`ifdef LATE_GRACE_EN
  localparam int GRACE_TICKS = 8;
  localparam int GRACE_W     = $clog2(GRACE_TICKS + 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // A wrong or missing key on a sounding note costs PEN_MISS unless the grace window hides it;
  // any key during a rest costs PEN_EXTRA.
  function automatic logic [PEN_W-1:0] calc_penalty(
    input logic [NOTE_W-1:0] exp_note,
    input logic [NOTE_W-1:0] key_note,
    input logic              suppress_miss
  );
    logic [PEN_W-1:0] pen;
    pen = 4'd0;
    if (exp_note != REST) begin
      if ((key_note != exp_note) && !suppress_miss) begin
        pen = PEN_MISS;
      end else begin
        pen = 4'd0;
      end
    end else if (key_note != REST) begin
      pen = PEN_EXTRA;
    end else begin
      pen = 4'd0;
    end
    return pen;
  endfunction

endpackage

// File: rtl/score_keeper_sat_add14.sv
// Combinational 14-bit saturating adder: a + b clamps at 14'h3FFF, sat flags the clamp.
module sat_add14
  import score_keeper_pkg::*;
(
  input  logic [SCORE_W-1:0] a,
  input  logic [PEN_W-1:0]   b,
  output logic [SCORE_W-1:0] sum,
  output logic               sat
);

  logic [SCORE_W:0] w_wide;

  assign w_wide = {1'b0, a} + {{(SCORE_W + 1 - PEN_W){1'b0}}, b};
  assign sat    = w_wide[SCORE_W];
  assign sum    = w_wide[SCORE_W] ? SCORE_MAX : w_wide[SCORE_W-1:0];

endmodule

// File: rtl/score_keeper.sv
// Learn-mode penalty score accumulator: IDLE/RUN/DONE control, saturating 14-bit score.
// Optional LATE_GRACE_EN macro adds a grace window after each expected-note change.
module score_keeper
  import score_keeper_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              tick,
  input  logic [NOTE_W-1:0] expect_note,
  input  logic [NOTE_W-1:0] key_note,
  output logic [SCORE_W-1:0] score,
  output logic              busy,
  output logic              valid
);

  state_t              r_state;
  state_t              w_next_state;
  logic [SCORE_W-1:0]  r_score;
  logic                r_busy;
  logic                r_valid;
  logic                w_suppress_miss;
  logic [PEN_W-1:0]    w_pen;
  logic [SCORE_W-1:0]  w_sum;
  logic                w_sat;
  logic                w_score_tick;

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // next-state decode; start always wins over stop
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_next_state = S_RUN;
        else       w_next_state = S_IDLE;
      end
      S_RUN: begin
        if (start)     w_next_state = S_RUN;
        else if (stop) w_next_state = S_DONE;
        else           w_next_state = S_RUN;
      end
      S_DONE: begin
        if (start) w_next_state = S_RUN;
        else       w_next_state = S_DONE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

`ifdef LATE_GRACE_EN
  logic [GRACE_W-1:0] r_grace;
  logic [GRACE_W-1:0] w_grace_eff;
  logic [NOTE_W-1:0]  r_prev_expect;

  // a note change counts in its own cycle, so the reload value applies to that tick
  always_comb begin
    w_grace_eff = r_grace;
    if ((r_state == S_RUN) && (expect_note != r_prev_expect)) begin
      w_grace_eff = GRACE_W'(GRACE_TICKS);
    end else begin
      w_grace_eff = r_grace;
    end
  end

  assign w_suppress_miss = (w_grace_eff != '0);

  // grace counter and previous-note tracker
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grace       <= '0;
      r_prev_expect <= REST;
    end else begin
      r_prev_expect <= expect_note;
      if (start) begin
        r_grace <= '0;
      end else if (r_state == S_RUN) begin
        if (tick && (w_grace_eff != '0)) begin
          r_grace <= w_grace_eff - GRACE_W'(1);
        end else begin
          r_grace <= w_grace_eff;
        end
      end else begin
        r_grace <= r_grace;
      end
    end
  end
`else
  assign w_suppress_miss = 1'b0;
`endif

  assign w_pen        = calc_penalty(expect_note, key_note, w_suppress_miss);
  assign w_score_tick = (r_state == S_RUN) && tick;

  sat_add14 u_sat_add14 (
    .a   (r_score),
    .b   (w_pen),
    .sum (w_sum),
    .sat (w_sat)
  );

  // score register: start clears, scored ticks accumulate, otherwise frozen
  always_ff @(posedge clk) begin
    if (rst) begin
      r_score <= '0;
    end else if (start) begin
      r_score <= '0;
    end else if (w_score_tick) begin
      r_score <= w_sat ? SCORE_MAX : w_sum;
    end else begin
      r_score <= r_score;
    end
  end

  // status flags track the state being entered so they line up with r_state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_busy  <= (w_next_state == S_RUN);
      r_valid <= (w_next_state == S_DONE);
    end
  end

  assign score = r_score;
  assign busy  = r_busy;
  assign valid = r_valid;

endmodule
